gray_counter: RTL



---
 rtl/gray_pkg.sv | 35 +++
 rtl/gray_counter_bin2gray.sv | 23 ++
 rtl/gray_counter.sv | 92 +++++++++
 3 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared constants and Binary/Gray conversion helpers for the
//               Gray counter family. The functions operate on MAX_WIDTH bits.
//               Narrower callers zero-extend on the way in and truncate on
//               the way out. The zero upper bits do not disturb the lower
//               bits in either direction.
// Contents    : DEFAULT_WIDTH - default counter width
//               MAX_WIDTH     - widest supported counter
//               bin2gray()    - b ^ (b >> 1)
//               gray2bin()    - prefix XOR running down from the MSB
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_counter_bin2gray.sv
`default_nettype none
// ============================================================================
// Module      : bin2gray
// Description : Combinational WIDTH-bit binary-to-Gray encoder. It is a thin
//               wrapper around the shared package function, so the counter
//               and any standalone use share one definition.
// Ports       : bin  in  WIDTH  binary value
//               gray out WIDTH  Gray code of bin
// Revision    : 1.0 - initial release
// ============================================================================
module bin2gray
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(gray_pkg::bin2gray(MAX_WIDTH'(bin)));

endmodule : bin2gray
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter
// Description : Registered up/down counter that holds a binary count and its
//               Gray-code image. Both values update on the same clock edge.
//               Every output comes straight from a flop, so the Gray bus
//               cannot glitch.
//               The priority on each edge is reset, then load, then count,
//               then hold.
// Ports       : clk      in  1      clock, rising edge
//               rst_n    in  1      synchronous active-low reset
//               en       in  1      count enable
//               up       in  1      1 = increment, 0 = decrement
//               load     in  1      synchronous load strobe
//               load_val in  WIDTH  binary value to load
//               bin      out WIDTH  registered binary count
//               gray     out WIDTH  registered Gray code of bin
//               wrap     out 1      one-cycle pulse after a wrap-around step
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_q;
  logic             wrap_d;

  // Next-state mux. Reset is applied in the flop block, so it overrides
  // whatever value this block selects.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + ONE;
        wrap_d = (bin_q == ALL_ONES);
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = (bin_q == ZERO);
      end
    end
  end

  // The Gray flop is fed from the encoded next value, not from the bin flop
  // output. This keeps gray registered and aligned with bin on every cycle.
  bin2gray #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .bin  (bin_d),
    .gray (gray_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= ZERO;
      gray_q <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule : gray_counter
`default_nettype wire
